fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Single-clock consumer for the read side of the async FIFO, running in the FIFO's read clock domain.
- Drives the FIFO's read enable from its empty flag and captures read data arriving FIFO_RD_LAT cycles later.
- Re-presents the captured words on a valid/ready stream through a 2-entry output buffer, with full throughput and no word loss under backpressure.
- Keeps a count of words delivered downstream.

Parameters:
- DATA_LEN, 32, data word width (matches the FIFO).
- FIFO_RD_LAT, 1, cycles from fifo_ren_o to valid fifo_rdata_i; legal values 0 or 1.
- CNT_LEN, 16, width of the delivered-word counter.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rdata_i  in  DATA_LEN  FIFO read data.
- fifo_ren_o  out  1  FIFO read enable; one pop per cycle high.
- m_valid_o  out  1  output word valid.
- m_data_o  out  DATA_LEN  output word.
- m_ready_i  in  1  downstream ready.
- rd_count_o  out  CNT_LEN  words accepted downstream, modulo 2^CNT_LEN.

Behaviour:
- Reset (async assert, released on clk): fifo_ren_o=0, m_valid_o=0, m_data_o=0, rd_count_o=0.
  - Buffer is empty, in-flight pipe is cleared, and both pointers are 0.
- State:
  - occ (0..2): words held in the buffer.
  - infl (0..FIFO_RD_LAT): reads issued whose data has not yet been captured.
  - Shift pipe of FIFO_RD_LAT bits marks capture cycles.
- Handshakes:
  - pop = m_valid_o & m_ready_i.
  - fifo_ren_o = !fifo_empty_i & ((occ+infl < 2) | (pop & occ+infl == 2)).
  - fifo_ren_o is combinational from registered state and the inputs; it never asserts while fifo_empty_i=1.
- Capture:
  - A word is written into the buffer tail at the clock edge in the cycle where the pipe indicates data valid (FIFO_RD_LAT=1: the cycle after ren; FIFO_RD_LAT=0: the same cycle as ren).
- Output:
  - m_valid_o = (occ != 0), registered.
  - m_data_o = the head entry, in FIFO order.
  - Minimum latency from ren to m_valid_o is FIFO_RD_LAT+1 cycles.
  - While m_valid_o=1 and m_ready_i=0, m_data_o and m_valid_o hold stable.
- Buffer:
  - Two entries, with 1-bit head and tail pointers that wrap 1->0.
  - occ_next = occ + capture - pop; a simultaneous capture and pop leaves occ unchanged.
  - occ+infl never exceeds 2, so no overflow is possible. Implementation carries an assertion for this.
- Throughput: with the FIFO non-empty and m_ready_i=1 held, one word per cycle in steady state.
- Counter:
  - rd_count_o increments by 1 on each pop and wraps from 2^CNT_LEN-1 to 0.
  - It is not reduced by reset-free events.
- Boundaries:
  - fifo_empty_i rising while a read is in flight: the in-flight word is still captured.
  - m_ready_i deasserted with occ=2: fifo_ren_o=0 until a pop.
  - m_ready_i asserted with m_valid_o=0: no effect.
- Reset mid-operation:
  - In-flight and buffered words are discarded.
  - All outputs return to reset values immediately, asynchronously.
  - fifo_ren_o=0 while rst=1.

Test Plan:
1. FIFO holds 0xA0..0xA7, m_ready_i=1, FIFO_RD_LAT=1 -> first m_valid_o 2 cycles after first ren; 8 consecutive words 0xA0..0xA7 in order on 8 consecutive cycles; rd_count_o=8.
2. FIFO holds 4 words, m_ready_i=0 -> exactly 2 ren pulses, occ=2, m_data_o=first word held stable; release m_ready_i -> all 4 words delivered in order, none lost or duplicated.
3. fifo_empty_i toggles every other cycle with random m_ready_i for 1000 words -> output sequence matches input sequence exactly; fifo_ren_o never high while fifo_empty_i=1.
4. Assert rst with occ=2 and one read in flight -> outputs 0 in the same cycle; after release with an empty FIFO, m_valid_o stays 0 and rd_count_o=0.
5. CNT_LEN=4, stream 17 words -> rd_count_o wraps 15->0 and ends at 1.
6. FIFO_RD_LAT=0, continuous stream with m_ready_i=1 -> m_valid_o one cycle after first ren; one word per cycle sustained.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO: pops words while buffer space is reserved,
// captures them FIFO_RD_LAT cycles later and replays them on a valid/ready stream.
module fifo_rd_stream #(
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned FIFO_RD_LAT = 1,
    parameter int unsigned CNT_LEN     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty_i,
    input  logic [DATA_LEN-1:0] fifo_rdata_i,
    output logic                fifo_ren_o,
    output logic                m_valid_o,
    output logic [DATA_LEN-1:0] m_data_o,
    input  logic                m_ready_i,
    output logic [CNT_LEN-1:0]  rd_count_o
);

    localparam int unsigned OCC_W = 2;
    localparam int unsigned DEPTH = 2;

    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                head_q, head_d;
    logic                tail_q, tail_d;
    logic [DATA_LEN-1:0] buf_q [DEPTH];
    logic [DATA_LEN-1:0] buf_d [DEPTH];
    logic                valid_q, valid_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic [CNT_LEN-1:0]  cnt_q, cnt_d;

    logic                infl_c;
    logic                capture_c;
    logic                pop_c;
    logic                ren_c;
    logic [OCC_W-1:0]    level_c;

    // Capture timing: same cycle as the read, or one cycle later via a 1-bit pipe.
    generate
        if (FIFO_RD_LAT == 0) begin : g_lat0
            assign infl_c    = 1'b0;
            assign capture_c = ren_c;
        end else begin : g_lat1
            logic pipe_q, pipe_d;

            always_comb begin
                pipe_d = ren_c;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= 1'b0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign infl_c    = pipe_q;
            assign capture_c = pipe_q;
        end
    endgenerate

    // Read only when a buffer slot is reserved for the word, counting the pop about to free one.
    always_comb begin
        level_c = occ_q + OCC_W'(infl_c);
        pop_c   = valid_q & m_ready_i;
        ren_c   = ~rst & ~fifo_empty_i &
                  ((level_c < 2'd2) | (pop_c & (level_c == 2'd2)));
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        buf_d  = buf_q;
        cnt_d  = cnt_q;

        if (capture_c) begin
            buf_d[tail_q] = fifo_rdata_i;
            tail_d        = ~tail_q;
        end

        if (pop_c) begin
            head_d = ~head_q;
            cnt_d  = cnt_q + CNT_LEN'(1);
        end

        case ({capture_c, pop_c})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        // Present the post-update head so outputs stay purely registered.
        valid_d = (occ_d != 2'd0);
        data_d  = buf_d[head_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q    <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            occ_q    <= occ_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            valid_q  <= valid_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    // Reserved slots can never exceed the buffer depth, and empty must block reads.
    always @(posedge clk) begin
        if (!rst) begin
            assert (level_c <= 2'd2);
            assert (!(ren_c && fifo_empty_i));
        end
    end

    assign fifo_ren_o = ren_c;
    assign m_valid_o  = valid_q;
    assign m_data_o   = data_q;
    assign rd_count_o = cnt_q;

endmodule
